// File: rtl/cpu_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_loader
// Purpose  : Host-side master for the CPU external memory ports. Takes a
//            32-bit header/payload word stream, writes program words (IMEM,
//            *_ext) and data words (DMEM, *_ext_2), reads DMEM back onto an
//            output stream, and enables the CPU for a bounded run.
// Options  : LOADER_CHECKSUM_EN - when defined, every write burst returns the
//            mod-2^32 sum of its payload words as one status word.
// Ports    : clk, arst_n (sync, active-low)
//            s_valid/s_ready/s_data   : command + payload input stream
//            m_valid/m_ready/m_data   : readback / status output stream
//            busy                     : loader not idle
//            cpu_enable               : CPU run enable
//            addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext           : IMEM
//            addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2 : DMEM
// Header   : [31:30] cmd (00 WR_IMEM, 01 WR_DMEM, 10 RD_DMEM, 11 RUN)
//            [29:16] N word/cycle count, [15:0] base word index
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_loader #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        busy,
  output logic        cpu_enable,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WR       = 3'd1;
  localparam logic [2:0] c_RD_ISSUE = 3'd2;
  localparam logic [2:0] c_RD_WAIT  = 3'd3;
  localparam logic [2:0] c_RD_SEND  = 3'd4;
  localparam logic [2:0] c_RUN      = 3'd5;
  localparam logic [2:0] c_STAT     = 3'd6;

  localparam logic [1:0] c_CMD_WR_IMEM = 2'b00;
  localparam logic [1:0] c_CMD_WR_DMEM = 2'b01;
  localparam logic [1:0] c_CMD_RD_DMEM = 2'b10;
  localparam logic [1:0] c_CMD_RUN     = 2'b11;

  localparam logic [1:0]  c_LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [31:0] c_RUN_TAG  = 32'h600D_0000;

  logic [2:0]  state_q, state_d;
  logic        sel_dmem_q, sel_dmem_d;
  logic [13:0] n_q, n_d;
  logic [13:0] i_q, i_d;
  logic [15:0] base_q, base_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [31:0] addr2_q, addr2_d;
  logic [31:0] wdata2_q, wdata2_d;
  logic        wen2_q, wen2_d;
  logic [31:0] mdata_q, mdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic [13:0] w_i_inc;
  logic        w_last;
  logic        w_unused_rdata;

  assign w_i_inc = i_q + 14'd1;
  assign w_last  = (w_i_inc == n_q);

  // IMEM read data is reserved; folded into a sink so it is visibly consumed.
  assign w_unused_rdata = ^rdata_ext;

  // Word index wraps silently at 16 bits before scaling to a byte address.
  function automatic logic [31:0] word_addr(input logic [15:0] base,
                                            input logic [13:0] idx);
    logic [15:0] w_idx;
    w_idx = base + {2'b00, idx};
    return {16'h0000, w_idx} * ADDR_STEP;
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= c_IDLE;
      sel_dmem_q <= 1'b0;
      n_q        <= '0;
      i_q        <= '0;
      base_q     <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      addr2_q    <= '0;
      wdata2_q   <= '0;
      wen2_q     <= 1'b0;
      mdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_dmem_q <= sel_dmem_d;
      n_q        <= n_d;
      i_q        <= i_d;
      base_q     <= base_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      addr2_q    <= addr2_d;
      wdata2_q   <= wdata2_d;
      wen2_q     <= wen2_d;
      mdata_q    <= mdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sel_dmem_d = sel_dmem_q;
    n_d        = n_q;
    i_d        = i_q;
    base_d     = base_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    addr2_d    = addr2_q;
    wdata2_d   = wdata2_q;
    wen2_d     = 1'b0;
    mdata_d    = mdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      c_IDLE: begin
        if (s_valid) begin
          sel_dmem_d = s_data[30];
          n_d        = s_data[29:16];
          base_d     = s_data[15:0];
          i_d        = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          // A zero count is a no-op for every command.
          if (s_data[29:16] != 14'd0) begin
            case (s_data[31:30])
              c_CMD_WR_IMEM, c_CMD_WR_DMEM: state_d = c_WR;
              c_CMD_RD_DMEM: begin
                state_d = c_RD_ISSUE;
                addr2_d = word_addr(s_data[15:0], 14'd0);
              end
              c_CMD_RUN: state_d = c_RUN;
              default: state_d = c_IDLE;
            endcase
          end
        end
      end

      c_WR: begin
        if (s_valid) begin
          if (sel_dmem_q) begin
            addr2_d  = word_addr(base_q, i_q);
            wdata2_d = s_data;
            wen2_d   = 1'b1;
          end else begin
            addr_d   = word_addr(base_q, i_q);
            wdata_d  = s_data;
            wen_d    = 1'b1;
          end
          i_d = w_i_inc;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data;
          if (w_last) begin
            state_d = c_STAT;
            mdata_d = sum_q + s_data;
          end
`else
          if (w_last) begin
            state_d = c_IDLE;
          end
`endif
        end
      end

      c_RD_ISSUE: begin
        state_d = c_RD_WAIT;
        lat_d   = '0;
      end

      // lat_q counts cycles since the read strobe; data is valid when it
      // reaches RD_LAT-1.
      c_RD_WAIT: begin
        if (lat_q == c_LAT_LAST) begin
          mdata_d = rdata_ext_2;
          state_d = c_RD_SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      c_RD_SEND: begin
        if (m_ready) begin
          if (w_last) begin
            state_d = c_IDLE;
          end else begin
            i_d     = w_i_inc;
            addr2_d = word_addr(base_q, w_i_inc);
            state_d = c_RD_ISSUE;
          end
        end
      end

      c_RUN: begin
        i_d = w_i_inc;
        if (w_last) begin
          mdata_d = c_RUN_TAG | {18'b0, n_q};
          state_d = c_STAT;
        end
      end

      c_STAT: begin
        if (m_ready) begin
          state_d = c_IDLE;
        end
      end

      default: state_d = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b1;
    cpu_enable = 1'b0;
    ren_ext_2  = 1'b0;
    case (state_q)
      c_IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
      end
      c_WR:               s_ready    = 1'b1;
      c_RD_ISSUE:         ren_ext_2  = 1'b1;
      c_RD_SEND, c_STAT:  m_valid    = 1'b1;
      c_RUN:              cpu_enable = 1'b1;
      default: ;
    endcase
  end

  assign ren_ext     = 1'b0;
  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext     = wen_q;
  assign addr_ext_2  = addr2_q;
  assign wdata_ext_2 = wdata2_q;
  assign wen_ext_2   = wen2_q;
  assign m_data      = mdata_q;

endmodule
`default_nettype wire
